// File: rtl/rvvi_pkg.sv
// Shared types and helpers for the RVVI trace packetizer.
// Holds FSM state encoding and frame header field offsets.
package rvvi_pkg;

    typedef enum logic [2:0] {INIT, IDLE, HDR, BODY, GAP} state_e;

    localparam int SEQ_LSB = 0;
    localparam int LEN_LSB = 16;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/rvvi_record_fifo.sv
// Synchronous record FIFO with registered occupancy.
// The head entry is presented combinationally (first-word fall-through).
module rvvi_record_fifo
    import rvvi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/rvvi_trace_packetizer.sv
// Buffers RVVI trace records and emits each as one AXI-Stream frame:
// a length/sequence header beat followed by the record sliced into beats.
module rvvi_trace_packetizer
    import rvvi_pkg::*;
#(
    parameter int          RECORD_BITS   = 232,
    parameter int          AXIS_W        = 32,
    parameter int          DEPTH         = 8,
    parameter int          STALL_MARGIN  = 2,
    parameter logic [31:0] INIT_TIME_OUT = 32'd4,
    parameter logic [31:0] PACKET_DELAY  = 32'd2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RecordValid,
    input  logic [RECORD_BITS-1:0] Record,
    output logic                   ExternalStall,
    output logic [AXIS_W-1:0]      TxTdata,
    output logic [AXIS_W/8-1:0]    TxTkeep,
    output logic                   TxTvalid,
    output logic                   TxTlast,
    input  logic                   TxTready,
    output logic [31:0]            FrameCount,
    output logic [15:0]            DropCount,
    output logic                   Overflow
);
    localparam int BYTES      = RECORD_BITS / 8;
    localparam int BPB        = AXIS_W / 8;
    localparam int BEATS      = ceil_div(BYTES, BPB);
    localparam int LAST_BYTES = BYTES - (BEATS - 1) * BPB;
    localparam int KW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW         = $clog2(DEPTH) + 1;

    localparam logic [BPB-1:0] LAST_KEEP = {BPB{1'b1}} >> (BPB - LAST_BYTES);
    localparam logic [KW-1:0]  K_LAST    = KW'(BEATS - 1);
    localparam logic [CW-1:0]  STALL_AT  = CW'(DEPTH - STALL_MARGIN);

    state_e              state_q;
    logic [31:0]         tmr_q;
    logic [31:0]         frames_q;
    logic [KW-1:0]       k_q;
    logic [KW-1:0]       k_d;
    logic [15:0]         seq_q;
    logic [15:0]         drops_q;
    logic                ovf_q;
    logic                tvalid_q;
    logic                tlast_q;
    logic [AXIS_W-1:0]   tdata_q;
    logic [BPB-1:0]      tkeep_q;

    logic [RECORD_BITS-1:0]  head;
    logic [CW-1:0]           count;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [BEATS*AXIS_W-1:0] rec_pad;

    function automatic logic [AXIS_W-1:0] hdr_word(input logic [15:0] s);
        logic [AXIS_W-1:0] w;
        w = '0;
        w[LEN_LSB +: 16] = 16'(BYTES);
        w[SEQ_LSB +: 16] = s;
        return w;
    endfunction

    always_comb begin
        pop  = (state_q == BODY) && tvalid_q && TxTready && tlast_q;
        push = RecordValid && (!full || pop);
        drop = RecordValid && !push;
        k_d  = k_q + 1'b1;
        rec_pad = '0;
        rec_pad[RECORD_BITS-1:0] = head;
    end

    rvvi_record_fifo #(
        .WIDTH (RECORD_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (Record),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= INIT;
            tmr_q    <= '0;
            k_q      <= '0;
            seq_q    <= '0;
            frames_q <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    tmr_q <= tmr_q + 32'd1;
                    if (tmr_q + 32'd1 >= INIT_TIME_OUT) begin
                        state_q <= IDLE;
                        tmr_q   <= '0;
                    end
                end
                IDLE: begin
                    if (!empty) begin
                        state_q  <= HDR;
                        tvalid_q <= 1'b1;
                        tdata_q  <= hdr_word(seq_q);
                        tkeep_q  <= '1;
                        tlast_q  <= 1'b0;
                    end
                end
                HDR: begin
                    if (TxTready) begin
                        state_q <= BODY;
                        k_q     <= '0;
                        tdata_q <= rec_pad[0 +: AXIS_W];
                        tkeep_q <= (BEATS == 1) ? LAST_KEEP : '1;
                        tlast_q <= (BEATS == 1);
                    end
                end
                BODY: begin
                    if (TxTready && tlast_q) begin
                        seq_q    <= seq_q + 16'd1;
                        frames_q <= frames_q + 32'd1;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        tmr_q    <= '0;
                        if (PACKET_DELAY != 32'd0) begin
                            state_q <= GAP;
                        end else if (count > CW'(1)) begin
                            // No gap configured: chain straight into the next header.
                            state_q  <= HDR;
                            tvalid_q <= 1'b1;
                            tdata_q  <= hdr_word(seq_q + 16'd1);
                            tkeep_q  <= '1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (TxTready) begin
                        k_q     <= k_d;
                        tdata_q <= rec_pad[int'(k_d)*AXIS_W +: AXIS_W];
                        tkeep_q <= (k_d == K_LAST) ? LAST_KEEP : '1;
                        tlast_q <= (k_d == K_LAST);
                    end
                end
                GAP: begin
                    tmr_q <= tmr_q + 32'd1;
                    if (tmr_q + 32'd1 >= PACKET_DELAY) begin
                        tmr_q <= '0;
                        if (!empty) begin
                            state_q  <= HDR;
                            tvalid_q <= 1'b1;
                            tdata_q  <= hdr_word(seq_q);
                            tkeep_q  <= '1;
                            tlast_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drops_q <= '0;
            ovf_q   <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drops_q != 16'hFFFF) drops_q <= drops_q + 16'd1;
        end
    end

    assign ExternalStall = (count >= STALL_AT);
    assign TxTdata       = tdata_q;
    assign TxTkeep       = tkeep_q;
    assign TxTvalid      = tvalid_q;
    assign TxTlast       = tlast_q;
    assign FrameCount    = frames_q;
    assign DropCount     = drops_q;
    assign Overflow      = ovf_q;

endmodule

// File: tb/tb_rvvi_trace_packetizer.sv
// Scoreboard bench for rvvi_trace_packetizer with 72-bit records on a 32-bit stream.
// Stimulus queues expected beats; a forked monitor pops and compares on each handshake.
module tb_rvvi_trace_packetizer;
    import rvvi_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RecordValid = 1'b0;
    logic [71:0] Record = '0;
    logic        TxTready = 1'b1;
    logic        ExternalStall;
    logic [31:0] TxTdata;
    logic [3:0]  TxTkeep;
    logic        TxTvalid;
    logic        TxTlast;
    logic [31:0] FrameCount;
    logic [15:0] DropCount;
    logic        Overflow;

    beat_t       sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          beats_seen = 0;
    int          base;
    int          n;
    logic [15:0] exp_seq = '0;
    logic        hold_v = 1'b0;
    beat_t       snap;

    rvvi_trace_packetizer #(
        .RECORD_BITS   (72),
        .AXIS_W        (32),
        .DEPTH         (8),
        .STALL_MARGIN  (2),
        .INIT_TIME_OUT (32'd4),
        .PACKET_DELAY  (32'd2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .RecordValid   (RecordValid),
        .Record        (Record),
        .ExternalStall (ExternalStall),
        .TxTdata       (TxTdata),
        .TxTkeep       (TxTkeep),
        .TxTvalid      (TxTvalid),
        .TxTlast       (TxTlast),
        .TxTready      (TxTready),
        .FrameCount    (FrameCount),
        .DropCount     (DropCount),
        .Overflow      (Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Header carries length 9 bytes and the sequence; last beat holds 1 byte.
    task automatic expect_rec(input logic [71:0] r);
        sb.push_back('{{16'h0009, exp_seq}, 4'hF, 1'b0});
        sb.push_back('{r[31:0], 4'hF, 1'b0});
        sb.push_back('{r[63:32], 4'hF, 1'b0});
        sb.push_back('{{24'h0, r[71:64]}, 4'h1, 1'b1});
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic mon_step();
        beat_t b;
        beat_t cur;
        cur = '{TxTdata, TxTkeep, TxTlast};
        if (reset) begin
            hold_v = 1'b0;
            return;
        end
        if (hold_v) begin
            n_cmp++;
            if (!TxTvalid || cur !== snap) begin
                n_err++;
                $display("FAIL stall_hold: valid=%b beat=%h held=%h", TxTvalid, cur, snap);
            end
        end
        hold_v = TxTvalid && !TxTready;
        snap = cur;
        if (TxTvalid && TxTready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL extra_beat: got %h with nothing expected", cur);
            end else begin
                b = sb.pop_front();
                if (cur !== b) begin
                    n_err++;
                    $display("FAIL beat%0d: got d=%h k=%h l=%b, want d=%h k=%h l=%b",
                             beats_seen, cur.d, cur.k, cur.l, b.d, b.k, b.l);
                end
                beats_seen++;
            end
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tlast(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(TxTvalid && TxTready && TxTlast) && k < 200);
        chk(name, 32'(TxTvalid && TxTready && TxTlast), 32'd1);
    endtask

    task automatic wait_beats(input string name, input int target);
        int k;
        k = 0;
        while (beats_seen < target && k < 200) begin
            cyc1();
            k++;
        end
        chk(name, 32'(beats_seen >= target), 32'd1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || TxTvalid) && k < 300) begin
            cyc1();
            k++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (3) cyc1();
        chk("rst_tvalid", 32'(TxTvalid), 32'd0);
        chk("rst_tdata", TxTdata, 32'd0);
        chk("rst_tkeep", 32'(TxTkeep), 32'd0);
        chk("rst_tlast", 32'(TxTlast), 32'd0);
        chk("rst_frames", FrameCount, 32'd0);
        chk("rst_drops", 32'(DropCount), 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chk("rst_stall", 32'(ExternalStall), 32'd0);

        // Two records pushed during the startup hold-off.
        reset = 1'b0;
        RecordValid = 1'b1;
        Record = 72'hAB_1122_3344_5566_7788;
        expect_rec(Record);
        cyc1();
        Record = 72'h5C_DEAD_BEEF_0BAD_F00D;
        expect_rec(Record);
        cyc1();
        RecordValid = 1'b0;
        n = 0;
        while (!TxTvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("init_holdoff", n, 32'd4);
        wait_tlast("frame_a");
        @(negedge clk);
        chk("gap1_valid", 32'(TxTvalid), 32'd0);
        chk("frames_1", FrameCount, 32'd1);
        @(negedge clk);
        chk("gap2_valid", 32'(TxTvalid), 32'd0);
        @(negedge clk);
        chk("hdr_b_valid", 32'(TxTvalid), 32'd1);
        chk("hdr_b_data", TxTdata, 32'h0009_0001);
        wait_tlast("frame_b");
        repeat (4) cyc1();

        // Backpressure mid-body.
        base = beats_seen;
        RecordValid = 1'b1;
        Record = 72'h77_0123_4567_89AB_CDEF;
        expect_rec(Record);
        cyc1();
        RecordValid = 1'b0;
        wait_beats("t3_sync", base + 2);
        TxTready = 1'b0;
        repeat (5) cyc1();
        TxTready = 1'b1;
        wait_tlast("frame_c");
        cyc1();
        chk("frames_3", FrameCount, 32'd3);
        repeat (4) cyc1();

        // Fill with the sink stalled: watermark, then two drops.
        TxTready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            Record = {8'(i + 1), 32'hC0DE_0000 + 32'(i), 32'h1234_5670 + 32'(i)};
            RecordValid = 1'b1;
            if (i < 8) expect_rec(Record);
            cyc1();
            chk("stall_wm", 32'(ExternalStall), 32'(i + 1 >= 6));
        end
        RecordValid = 1'b0;
        chk("drop_count", 32'(DropCount), 32'd2);
        chk("overflow", 32'(Overflow), 32'd1);

        // Push in the same cycle as the final-beat pop of a full FIFO.
        cyc1();
        TxTready = 1'b1;
        wait_tlast("t5_first");
        Record = 72'hEE_FACE_CAFE_1357_2468;
        RecordValid = 1'b1;
        expect_rec(Record);
        cyc1();
        RecordValid = 1'b0;
        chk("swap_occ", 32'(dut.u_fifo.count_q), 32'd8);
        chk("swap_drops", 32'(DropCount), 32'd2);
        chk("swap_stall", 32'(ExternalStall), 32'd1);
        drain("t5_drain");
        chk("frames_12", FrameCount, 32'd12);
        repeat (3) cyc1();

        // Reset while body beat 1 is on the bus.
        base = beats_seen;
        RecordValid = 1'b1;
        Record = 72'h99_8888_7777_6666_5555;
        expect_rec(Record);
        cyc1();
        RecordValid = 1'b0;
        wait_beats("t6_sync", base + 2);
        reset = 1'b1;
        cyc1();
        chk("midrst_valid", 32'(TxTvalid), 32'd0);
        chk("midrst_frames", FrameCount, 32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'(INIT));
        chk("midrst_drops", 32'(DropCount), 32'd0);
        chk("midrst_ovf", 32'(Overflow), 32'd0);
        sb.delete();
        exp_seq = '0;
        reset = 1'b0;
        RecordValid = 1'b1;
        Record = 72'h42_0F0F_0F0F_F0F0_F0F0;
        expect_rec(Record);
        cyc1();
        RecordValid = 1'b0;
        drain("t6_drain");
        chk("frames_after_rst", FrameCount, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
